bus_source_arbiter: RTL and testbench

//  Round-robin arbiter for the 32 shared-bus driver sources (registers, PC, IR, MDR, ALU result, ...).

---
 rtl/cpu_bus_pkg.sv | 19 +
 rtl/rr_priority_pick.sv | 30 +++
 rtl/bus_source_arbiter.sv | 107 ++++++++++
 tb/tb_bus_source_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU internal-bus source arbitration logic.
// Source count is tied to the 5-bit bus select that the grant encoder produces.
package cpu_bus_pkg;

    localparam int NSRC       = 32;
    localparam int BUS_SEL_W  = 5;
    localparam int HOLD_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    function automatic logic [NSRC-1:0] onehot(input logic [BUS_SEL_W-1:0] idx);
        return NSRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: index of the first set request bit at or
// after base, wrapping from bit 31 back to bit 0.
module rr_priority_pick
    import cpu_bus_pkg::*;
(
    input  logic [NSRC-1:0]      req,
    input  logic [BUS_SEL_W-1:0] base,
    output logic                 found,
    output logic [BUS_SEL_W-1:0] idx
);

    logic [2*NSRC-1:0]    req_dbl;
    logic [NSRC-1:0]      req_rot;
    logic [BUS_SEL_W-1:0] offset;

    // Rotating right by base turns the wrapped scan into a plain lowest-bit search.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[base +: NSRC];
        offset  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = BUS_SEL_W'(i);
            end
        end
        found = |req;
        idx   = base + offset;
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter for the shared-bus driver sources; issues a registered
// grant that is always zero or one-hot, with a bus-turnaround gap between owners.
module bus_source_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [NSRC-1:0] req,
    input  logic            done,
    output logic [NSRC-1:0] grant,
    output logic            grant_valid,
    output logic            timeout
);

    arb_state_e            state, state_nx;
    logic [BUS_SEL_W-1:0]  ptr, ptr_nx;
    logic [BUS_SEL_W-1:0]  owner, owner_nx;
    logic [HOLD_CNT_W-1:0] hold_cnt, hold_nx;
    logic [NSRC-1:0]       grant_nx;
    logic                  grant_valid_nx;
    logic                  timeout_nx;

    logic                  pick_found;
    logic [BUS_SEL_W-1:0]  pick_idx;

    logic                  rel_req;
    logic                  rel_hold;
    logic                  release_now;

    rr_priority_pick u_pick (
        .req   (req),
        .base  (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign rel_req     = !req[owner];
    assign rel_hold    = (MAX_HOLD != 0) && (hold_cnt == HOLD_CNT_W'(MAX_HOLD));
    assign release_now = done || rel_req || rel_hold;

    always_comb begin
        state_nx       = state;
        ptr_nx         = ptr;
        owner_nx       = owner;
        hold_nx        = hold_cnt;
        grant_nx       = grant;
        grant_valid_nx = grant_valid;
        timeout_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nx       = pick_idx;
                    grant_nx       = onehot(pick_idx);
                    grant_valid_nx = 1'b1;
                    hold_nx        = HOLD_CNT_W'(1);
                    state_nx       = OWN;
                end
            end
            OWN: begin
                if (release_now) begin
                    grant_nx       = '0;
                    grant_valid_nx = 1'b0;
                    ptr_nx         = owner + BUS_SEL_W'(1);
                    // A timeout is reported only when the hold limit alone forced the release.
                    timeout_nx     = rel_hold && !done && !rel_req;
                    state_nx       = GAP;
                end else if (hold_cnt != '1) begin
                    hold_nx = hold_cnt + HOLD_CNT_W'(1);
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                grant_nx       = '0;
                grant_valid_nx = 1'b0;
                state_nx       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            hold_cnt    <= hold_nx;
            grant       <= grant_nx;
            grant_valid <= grant_valid_nx;
            timeout     <= timeout_nx;
        end
    end

    // Owner index is only consulted while in OWN, so it needs no reset.
    always_ff @(posedge clk) begin
        owner <= owner_nx;
    end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Scoreboard bench for bus_source_arbiter: a transaction-level model predicts
// grant/grant_valid/timeout each cycle; a monitor compares on the falling edge.
module tb_bus_source_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] req;
    logic        done;
    logic [31:0] grant;
    logic        grant_valid;
    logic        timeout;

    typedef struct packed {
        logic [31:0] g;
        logic        v;
        logic        t;
    } exp_s;

    exp_s q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_timeouts = 0;

    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    bit   m_gap   = 1'b0;

    bus_source_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .clr         (clr),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bus is either free, in turnaround, or owned by one source.
    task automatic model_step();
        bit exp_to = 1'b0;
        if (clr) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_gap   = 1'b0;
        end else if (m_owner >= 0) begin
            bit limit = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (done || !req[m_owner] || limit) begin
                exp_to  = limit && !done && req[m_owner];
                m_ptr   = (m_owner + 1) % 32;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_held = (m_held < 255) ? m_held + 1 : 255;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            int pick = -1;
            for (int k = 0; k < 32; k++) begin
                int s = (m_ptr + k) % 32;
                if (req[s] && pick < 0) pick = s;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_held  = 1;
            end
        end
        q.push_back('{g: (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0,
                      v: (m_owner >= 0), t: exp_to});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        exp_s e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("grant", grant, e.g);
                check("grant_valid", {31'b0, grant_valid}, {31'b0, e.v});
                check("timeout", {31'b0, timeout}, {31'b0, e.t});
                check("grant_onehot0", {31'b0, $onehot0(grant)}, 32'h1);
                check("valid_matches_grant", {31'b0, grant_valid}, {31'b0, |grant});
                if (timeout) n_timeouts++;
            end
        end
    end

    task automatic cyc(input logic [31:0] r, input logic d, input logic c);
        req  = r;
        done = d;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [31:0] r, input logic [31:0] g);
        int n = 0;
        while (grant !== g && n < 40) begin
            cyc(r, 1'b0, 1'b0);
            n++;
        end
        if (grant !== g) begin
            tests++;
            fails++;
            $display("FAIL wait_grant: grant %h never reached %h", grant, g);
        end
    endtask

    initial begin
        logic [31:0] r;
        cyc(32'h0, 1'b0, 1'b1);
        cyc(32'h0, 1'b0, 1'b1);

        // Single requester, released by done.
        for (int i = 0; i < 4; i++) cyc(32'h0000_0010, 1'b0, 1'b0);
        cyc(32'h0000_0010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(32'h0, 1'b0, 1'b0);

        // Two requesters at opposite ends alternate.
        cyc(32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) cyc(32'h8000_0001, (i % 3) == 2, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);

        // Pointer wrap: grant bit 30, then bit 2 from ptr=31.
        wait_grant(32'h4000_0000, 32'h4000_0000);
        cyc(32'h4000_0000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(32'h0000_0004, i == 3, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);

        // Hold limit: timeout and re-grant.
        for (int i = 0; i < 16; i++) cyc(32'h0000_0100, 1'b0, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);

        // Owner 7 drops req with done exactly at the hold limit.
        wait_grant(32'h0000_0080, 32'h0000_0080);
        for (int i = 0; i < MAX_HOLD - 1; i++) cyc(32'h0000_0080, 1'b0, 1'b0);
        cyc(32'h0, 1'b1, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);

        // Reset while owned, then grant from fresh pointer.
        wait_grant(32'h0000_0400, 32'h0000_0400);
        cyc(32'h0000_0400, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(32'h0000_0800, 1'b0, 1'b0);

        // Randomized traffic.
        r = 32'h0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) begin
                r = 32'h0;
                for (int b = 0; b < $urandom_range(4); b++) r[$urandom_range(31)] = 1'b1;
            end
            cyc(r, $urandom_range(5) == 0, $urandom_range(199) == 0);
        end

        cyc(32'h0, 1'b0, 1'b0);
        cyc(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("timeouts_observed", {31'b0, (n_timeouts > 0)}, 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
